mod_updown_counter: RTL and testbench

Parametrised modulo-N up/down counter: the general-purpose successor to the fixed 4-bit free-running counter. It adds configurable width and modulus, direction control, enable, synchronous clear, parallel load, an optional clock-enable prescaler, and terminal-count and wrap indications. It is used for timers, event counters and address sequencers across the design.

---
 rtl/mod_counter_pkg.sv | 19 +
 rtl/cnt_prescaler.sv | 49 ++++
 rtl/mod_updown_counter.sv | 105 ++++++++++
 tb/tb_mod_updown_counter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulo up/down counter family: direction
// encodings and the parameter-legality check evaluated at elaboration.
package mod_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // WIDTH is capped at 30 so that 2**WIDTH (the default MODULUS) still fits
  // in a signed 32-bit parameter without overflow.
  function automatic bit params_ok(input int width, input int modulus, input int prescale);
    int span;
    if (width < 1 || width > 30) begin
      return 1'b0;
    end
    span = 1 << width;
    return (modulus >= 2) && (modulus <= span) && (prescale >= 1);
  endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Clock-enable prescaler: emits one tick every PRESCALE enabled cycles.
// en=0 freezes the phase; clr_i returns the phase to zero. With PRESCALE=1
// the block collapses to tick=en and holds no state.
module cnt_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en,
  output logic tick
);

  if (PRESCALE == 1) begin : g_bypass
    // Clock, reset and clear have no state to act on in the bypass case.
    logic unused_bypass;
    assign unused_bypass = &{1'b0, clk, reset, clr_i};
    assign tick = en;
  end else begin : g_div
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    // Next phase: clear wins, otherwise advance on enabled cycles and fold at LAST.
    always_comb begin
      phase_d = phase_q;
      if (clr_i) begin
        phase_d = '0;
      end else if (en) begin
        phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
      end
    end

    // Phase register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        phase_q <= '0;
      end else begin
        phase_q <= phase_d;
      end
    end

    // Tick on the enabled cycle that completes the prescale period.
    assign tick = en && (phase_q == LAST);
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised modulo-N up/down counter with enable, synchronous clear,
// clamped parallel load, optional prescaler, combinational terminal count
// and a registered wrap pulse aligned with the post-wrap count.
// Build option: define MOD_COUNTER_SAT_EN to saturate at the range ends
// instead of wrapping (wrap then stays low).
module mod_updown_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 2 ** WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  if (!params_ok(WIDTH, MODULUS, PRESCALE)) begin : g_param_err
    $error("mod_updown_counter: illegal parameters WIDTH=%0d MODULUS=%0d PRESCALE=%0d",
           WIDTH, MODULUS, PRESCALE);
  end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic [WIDTH-1:0] load_clamped;
  logic             tick;

  // Both clear and load restart the prescale period so the next step is a
  // full period away.
  cnt_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr_i(clr | load),
    .en   (en),
    .tick (tick)
  );

  assign load_clamped = (load_val > MAX_CNT) ? MAX_CNT : load_val;

  // Next count and wrap: clr > load > step > hold. Range ends are detected by
  // comparison, never by natural overflow, so non-power-of-two moduli work.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_clamped;
    end else if (tick) begin
      if (up_dn == DIR_UP) begin
        if (count_q == MAX_CNT) begin
`ifdef MOD_COUNTER_SAT_EN
          count_d = MAX_CNT;
`else
          count_d = '0;
          wrap_d  = 1'b1;
`endif
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
`ifdef MOD_COUNTER_SAT_EN
          count_d = '0;
`else
          count_d = MAX_CNT;
          wrap_d  = 1'b1;
`endif
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // Count and wrap registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Terminal count follows the current direction with no register delay.
  assign tc    = (up_dn == DIR_UP) ? (count_q == MAX_CNT) : (count_q == '0);
  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter. Two instances: A (WIDTH=4,
// MODULUS=10, PRESCALE=1) and B (WIDTH=8, MODULUS=256, PRESCALE=3).
// Stimulus pushes hand-computed expectations; a monitor pops one entry
// after every clock edge (or on an explicit mid-cycle sample) and compares.
module tb_mod_updown_counter;

`ifdef MOD_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic reset;
  logic rst_v;

  logic       a_clr, a_en, a_up, a_load;
  logic [3:0] a_lv;
  logic [3:0] a_count;
  logic       a_tc, a_wrap;

  logic       b_clr, b_en, b_up, b_load;
  logic [7:0] b_lv;
  logic [7:0] b_count;
  logic       b_tc, b_wrap;

  typedef struct {
    int    dut;
    int    cnt;
    bit    tc;
    bit    wrap;
    string name;
  } exp_t;

  exp_t sb_q[$];
  int   vectors;
  int   miscompares;
  event sample_ev;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_dut_a (
    .clk(clk), .reset(reset), .clr(a_clr), .en(a_en), .up_dn(a_up),
    .load(a_load), .load_val(a_lv), .count(a_count), .tc(a_tc), .wrap(a_wrap)
  );

  mod_updown_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(3)) u_dut_b (
    .clk(clk), .reset(reset), .clr(b_clr), .en(b_en), .up_dn(b_up),
    .load(b_load), .load_val(b_lv), .count(b_count), .tc(b_tc), .wrap(b_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regular sample point, well after the active edge.
  always begin
    @(posedge clk);
    #2;
    ->sample_ev;
  end

  task automatic check(input exp_t e);
    logic [7:0] c;
    logic       t;
    logic       w;
    if (e.dut == 0) begin
      c = {4'b0000, a_count};
      t = a_tc;
      w = a_wrap;
    end else begin
      c = b_count;
      t = b_tc;
      w = b_wrap;
    end
    vectors++;
    if (c !== 8'(e.cnt) || t !== e.tc || w !== e.wrap) begin
      miscompares++;
      $display("FAIL %s: got count=%0d tc=%0b wrap=%0b, want count=%0d tc=%0b wrap=%0b",
               e.name, c, t, w, e.cnt, e.tc, e.wrap);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(sample_ev);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e);
      end
    end
  end

  // One vector per cycle: drive the chosen instance, idle the other one.
  task automatic drive(input int d, input bit clr, input bit en, input bit up, input bit ld,
                       input int lv, input int c, input bit t, input bit w, input string n);
    @(negedge clk);
    reset = rst_v;
    if (d == 0) begin
      a_clr = clr; a_en = en; a_up = up; a_load = ld; a_lv = 4'(lv);
      b_clr = 1'b0; b_en = 1'b0; b_load = 1'b0;
    end else begin
      b_clr = clr; b_en = en; b_up = up; b_load = ld; b_lv = 8'(lv);
      a_clr = 1'b0; a_en = 1'b0; a_load = 1'b0;
    end
    sb_q.push_back('{dut: d, cnt: c, tc: t, wrap: w, name: n});
  endtask

  // Assert reset between edges and sample before the next edge arrives.
  task automatic async_reset_check(input int c, input bit t, input string n);
    @(negedge clk);
    #2;
    reset = 1'b1;
    rst_v = 1'b1;
    sb_q.push_back('{dut: 0, cnt: c, tc: t, wrap: 1'b0, name: n});
    #1;
    ->sample_ev;
  endtask

  task automatic run_mod_a();
    int up_seq[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 1, 0, 0, up_seq[i], (i == 8), (i == 9), $sformatf("a_up_%0d", i));
    end
    drive(0, 0, 1, 0, 0, 0, 9, 0, 1, "a_down_wrap");
    drive(0, 0, 1, 0, 0, 0, 8, 0, 0, "a_down_8");
    drive(0, 0, 1, 0, 0, 0, 7, 0, 0, "a_down_7");
    drive(0, 0, 1, 0, 0, 0, 6, 0, 0, "a_down_6");
    drive(0, 0, 1, 0, 0, 0, 5, 0, 0, "a_down_5");
    async_reset_check(0, 1, "a_async_reset");
    drive(0, 0, 1, 0, 0, 0, 0, 1, 0, "a_reset_hold");
    rst_v = 1'b0;
    drive(0, 0, 1, 1, 0, 0, 1, 0, 0, "a_resume");
    drive(0, 1, 1, 1, 1, 7, 0, 0, 0, "a_clr_over_load");
    drive(0, 0, 1, 1, 1, 12, 9, 1, 0, "a_load_clamp");
    drive(0, 0, 1, 1, 0, 0, 0, 0, 1, "a_wrap_after_load");
    drive(0, 0, 1, 1, 1, 9, 9, 1, 0, "a_load_clears_wrap");
    drive(0, 0, 0, 1, 0, 0, 9, 1, 0, "a_hold_en0");
    drive(0, 0, 0, 0, 0, 0, 9, 0, 0, "a_tc_follows_dir");
    drive(0, 1, 1, 0, 0, 0, 0, 1, 0, "a_clr");
    drive(0, 0, 1, 0, 0, 0, 9, 0, 1, "a_down_wrap2");
    drive(0, 1, 1, 0, 0, 0, 0, 1, 0, "a_clr_clears_wrap");
  endtask

  task automatic run_sat_a();
    rst_v = 1'b0;
    drive(0, 0, 1, 1, 1, 9, 9, 1, 0, "a_sat_load9");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 0, 0, 9, 1, 0, $sformatf("a_sat_up_%0d", i));
    end
    drive(0, 1, 1, 0, 0, 0, 0, 1, 0, "a_sat_clr");
    drive(0, 0, 1, 0, 0, 0, 0, 1, 0, "a_sat_down_0");
    drive(0, 0, 1, 0, 0, 0, 0, 1, 0, "a_sat_down_1");
  endtask

  task automatic run_b();
    int pre_seq[9] = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
    rst_v = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 1, 1, 0, 0, pre_seq[i], 0, 0, $sformatf("b_pre_%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 1, 0, 0, 3, 0, 0, $sformatf("b_frozen_%0d", i));
    end
    drive(1, 0, 1, 1, 0, 0, 3, 0, 0, "b_resume_1");
    drive(1, 0, 1, 1, 0, 0, 3, 0, 0, "b_resume_2");
    drive(1, 0, 1, 1, 0, 0, 4, 0, 0, "b_resume_tick");
    drive(1, 1, 1, 0, 0, 0, 0, 1, 0, "b_clr");
    drive(1, 0, 1, 0, 0, 0, 0, 1, 0, "b_down_ph1");
    drive(1, 0, 1, 0, 0, 0, 0, 1, 0, "b_down_ph2");
    if (SAT) drive(1, 0, 1, 0, 0, 0, 0, 1, 0, "b_down_sat");
    else     drive(1, 0, 1, 0, 0, 0, 255, 0, 1, "b_down_wrap");
    drive(1, 0, 1, 0, 0, 0, SAT ? 0 : 255, SAT, 0, "b_down_hold_phase");
    drive(1, 0, 1, 1, 1, 200, 200, 0, 0, "b_load200");
    drive(1, 0, 1, 1, 0, 0, 200, 0, 0, "b_load_ph1");
    drive(1, 0, 1, 1, 0, 0, 200, 0, 0, "b_load_ph2");
    drive(1, 0, 1, 1, 0, 0, 201, 0, 0, "b_load_tick");
  endtask

  initial begin : stimulus
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    rst_v = 1'b1;
    a_clr = 1'b0; a_en = 1'b0; a_up = 1'b1; a_load = 1'b0; a_lv = 4'd0;
    b_clr = 1'b0; b_en = 1'b0; b_up = 1'b1; b_load = 1'b0; b_lv = 8'd0;

    drive(0, 0, 1, 1, 0, 0, 0, 0, 0, "a_reset_state");
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, "b_reset_state");
    rst_v = 1'b0;
`ifdef MOD_COUNTER_SAT_EN
    run_sat_a();
`else
    run_mod_a();
`endif
    run_b();

    repeat (3) @(posedge clk);
    #3;
    if (sb_q.size() != 0) begin
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
      miscompares += sb_q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
